pipe_skid_reg: RTL



---
 rtl/pipe_skid_reg.sv | 118 +++++++++++
 1 files changed

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: inter-stage pipeline register built as a 2-entry skid buffer.
// in_ready comes from registered state only, so there is no combinational
// path from out_ready to in_ready.
//
// Ports:
//   clk, reset_n       rising-edge clock, synchronous active-low reset
//   in_valid/in_ready  upstream handshake; in_data is the upstream bundle
//   out_valid/out_ready downstream handshake; out_data is the main entry
//   flush              discard all held entries
//   occupancy          number of valid entries, 0..2
//   stall_count        saturating count of out_valid=1 & out_ready=0 cycles
module pipe_skid_reg #(
   parameter int unsigned WIDTH          = 16,
   parameter int unsigned CNT_WIDTH      = 8,
   parameter bit          CLEAR_ON_FLUSH = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   input  logic                 flush,
   output logic [1:0]           occupancy,
   output logic [CNT_WIDTH-1:0] stall_count
);

   localparam logic [CNT_WIDTH-1:0] STALL_MAX = '1;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] skid_data;
   logic             push;
   logic             pop;

   // Handshakes use only registered outputs.
   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   // State, registered status outputs, data entries and stall counter.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= EMPTY;
         out_valid   <= 1'b0;
         in_ready    <= 1'b1;
         occupancy   <= 2'd0;
         stall_count <= '0;
         out_data    <= '0;
         skid_data   <= '0;
      end else begin
         // Counts every blocked cycle regardless of flush; only reset clears it.
         if (out_valid && !out_ready && (stall_count != STALL_MAX)) begin
            stall_count <= stall_count + CNT_WIDTH'(1);
         end

         if (flush) begin
            // A concurrent pop completes implicitly: the entry is simply dropped.
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            occupancy <= 2'd0;
            if (CLEAR_ON_FLUSH) begin
               out_data  <= '0;
               skid_data <= '0;
            end
         end else begin
            case (state)
               EMPTY: begin
                  if (push) begin
                     state     <= ONE;
                     out_valid <= 1'b1;
                     in_ready  <= 1'b1;
                     occupancy <= 2'd1;
                     out_data  <= in_data;
                  end
               end
               ONE: begin
                  if (push && pop) begin
                     out_data <= in_data;
                  end else if (push) begin
                     // Downstream stalled: park the new word in the skid entry.
                     state     <= FULL;
                     in_ready  <= 1'b0;
                     occupancy <= 2'd2;
                     skid_data <= in_data;
                  end else if (pop) begin
                     state     <= EMPTY;
                     out_valid <= 1'b0;
                     occupancy <= 2'd0;
                  end
               end
               FULL: begin
                  if (pop) begin
                     state     <= ONE;
                     in_ready  <= 1'b1;
                     occupancy <= 2'd1;
                     out_data  <= skid_data;
                  end
               end
               default: begin
                  state     <= EMPTY;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  occupancy <= 2'd0;
               end
            endcase
         end
      end
   end

endmodule
